// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes. Divide corner cases complete in one cycle.
module muldiv_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     kill,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    Result
);

   localparam int N  = DATA_WIDTH;
   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t         state_reg, state_next;
   logic [2:0]     op_reg, op_next;
   logic           neg_res_reg, neg_res_next;
   logic           neg_rem_reg, neg_rem_next;
   logic [N-1:0]   mcand_reg, mcand_next;
   logic [N-1:0]   acc_reg, acc_next;
   logic [N-1:0]   lo_reg, lo_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [N-1:0]   result_reg, result_next;

   // Launch-time decode of the incoming operands
   logic [2:0]     op_in;
   logic           sign_a, sign_b;
   logic           div_zero, div_ovf;
   logic [N-1:0]   mag_a, mag_b, fast_result;

   always_comb begin
      op_in    = Operation[2:0];
      sign_a   = SrcA[N-1] & ((op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                              (op_in == OP_DIV)  || (op_in == OP_REM));
      sign_b   = SrcB[N-1] & ((op_in == OP_MULH) || (op_in == OP_DIV) ||
                              (op_in == OP_REM));
      mag_a    = sign_a ? -SrcA : SrcA;
      mag_b    = sign_b ? -SrcB : SrcB;
      div_zero = op_in[2] && (SrcB == '0);
      div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (SrcA == MIN_NEG) && (SrcB == '1);
      // op_in[1] separates remainder ops from quotient ops
      if (div_zero) begin
         fast_result = op_in[1] ? SrcA : '1;
      end else begin
         fast_result = op_in[1] ? '0 : SrcA;
      end
   end

   // One iteration of the datapath plus the sign fix-up applied on the final step
   logic [N:0]     mul_sum;
   logic [N:0]     div_shift;
   logic           div_ge;
   logic [N-1:0]   div_sub;
   logic [N-1:0]   step_acc, step_lo;
   logic [2*N-1:0] prod_mag, prod_fix;
   logic [N-1:0]   quo_fix, rem_fix, calc_result;

   always_comb begin
      mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
      div_shift = {acc_reg, lo_reg[N-1]};
      div_ge    = (div_shift >= {1'b0, mcand_reg});
      div_sub   = div_shift[N-1:0] - mcand_reg;
      if (op_reg[2]) begin
         step_acc = div_ge ? div_sub : div_shift[N-1:0];
         step_lo  = {lo_reg[N-2:0], div_ge};
      end else begin
         step_acc = mul_sum[N:1];
         step_lo  = {mul_sum[0], lo_reg[N-1:1]};
      end
      prod_mag = {step_acc, step_lo};
      prod_fix = neg_res_reg ? -prod_mag : prod_mag;
      quo_fix  = neg_res_reg ? -step_lo : step_lo;
      rem_fix  = neg_rem_reg ? -step_acc : step_acc;
      case (op_reg)
         OP_MUL:                       calc_result = prod_fix[N-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_fix[2*N-1:N];
         OP_DIV, OP_DIVU:              calc_result = quo_fix;
         default:                      calc_result = rem_fix;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      neg_res_next = neg_res_reg;
      neg_rem_next = neg_rem_reg;
      mcand_next   = mcand_reg;
      acc_next     = acc_reg;
      lo_next      = lo_reg;
      cnt_next     = cnt_reg;
      result_next  = result_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               // Multiplication commutes, so both op classes share one layout:
               // lo holds A (multiplier / dividend), mcand holds B.
               op_next      = op_in;
               neg_res_next = sign_a ^ sign_b;
               neg_rem_next = sign_a;
               mcand_next   = mag_b;
               lo_next      = mag_a;
               acc_next     = '0;
               if (div_zero || div_ovf) begin
                  result_next = fast_result;
                  cnt_next    = '0;
                  state_next  = FIN;
               end else begin
                  cnt_next    = CW'(N);
                  state_next  = CALC;
               end
            end
         end
         CALC: begin
            acc_next = step_acc;
            lo_next  = step_lo;
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               result_next = calc_result;
               state_next  = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (kill) begin
         state_next  = IDLE;
         result_next = result_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         op_reg      <= '0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         mcand_reg   <= '0;
         acc_reg     <= '0;
         lo_reg      <= '0;
         cnt_reg     <= '0;
         result_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         neg_res_reg <= neg_res_next;
         neg_rem_reg <= neg_rem_next;
         mcand_reg   <= mcand_next;
         acc_reg     <= acc_next;
         lo_reg      <= lo_next;
         cnt_reg     <= cnt_next;
         result_reg  <= result_next;
      end
   end

   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == FIN);
   assign Result = result_reg;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M operation set. It sits beside the combinational `alu` in the EX stage: the pipeline launches an operation with a one-cycle `start`, stalls on `busy`, and captures `Result` when `done` pulses. Width is generic. Operands use shift-add and restoring-division datapaths at one bit per cycle, with fast-path completion for divide corner cases.

## Interface
- `DATA_WIDTH`, 32: operand and result width N; N ≥ 4, even.
- `OPCODE_LENGTH`, 3: width of `Operation`. Operation values are RV32M funct3 codes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `kill`  in  1  pipeline flush; aborts any in-flight operation.
- `Operation`  in  OPCODE_LENGTH  op code:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `SrcA`  in  DATA_WIDTH  multiplicand / dividend; captured at launch.
- `SrcB`  in  DATA_WIDTH  multiplier / divisor; captured at launch.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  single-cycle completion strobe.
- `Result`  out  DATA_WIDTH  registered result; valid while `done`=1 and held until the next launch.

## Operation
- **FSM states:** IDLE, CALC, FIN.
- **Launch:** in IDLE with `start`=1 and `kill`=0, the unit latches the operands, the op code, the operand signs and the magnitudes.
  - Signed operands: MULH A,B; MULHSU A only; DIV and REM A,B. All other operands are unsigned.
  - Divide by zero (B=0) goes directly to FIN:
    - DIV/DIVU return all-ones.
    - REM/REMU return A.
  - Signed overflow (DIV/REM with A=−2^(N−1), B=−1) goes directly to FIN:
    - DIV returns A.
    - REM returns 0.
  - Otherwise the FSM enters CALC and loads the bit counter with N.
- **CALC, multiply:** each cycle, conditionally add the multiplicand to the 2N-bit partial product, then shift. This is done on magnitudes.
- **CALC, divide:** each cycle, perform one restoring step: shift the remainder left, trial-subtract the divisor, and set the quotient bit. This is done on magnitudes.
- **CALC exit:** when the counter reaches 0, go to FIN.
- **CALC→FIN sign fix-up:**
  - Negate the product if the operand signs differ.
  - Negate the quotient if the operand signs differ.
  - Give the remainder the sign of the dividend.
- **Result selection:**
  - MUL: low N bits of the product.
  - MULH, MULHSU, MULHU: high N bits of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- **FIN:** `done`=1 for exactly this cycle, then the FSM returns to IDLE.
- **`start` handling:** `start` is ignored in CALC and FIN, so no queuing occurs. `start` in the IDLE cycle following FIN is accepted.
- **`kill`:** in any state, `kill`=1 forces IDLE on the next edge.
  - `done` is not asserted for the aborted operation.
  - `Result` keeps its previous value.
  - `kill` has priority over `start` in the same cycle.
- **`reset`:** has priority over everything, including mid-operation.
  - Next state is IDLE.
  - `busy`=0, `done`=0, `Result`=0, counter=0.

## Timing
- Let the launch be sampled at edge k.
- Normal operation:
  - CALC occupies cycles k+1 … k+N.
  - FIN (`done`=1) is cycle k+N+1.
  - Latency is N+1 cycles (33 for N=32).
- Fast path: FIN is cycle k+1, for a latency of 1 cycle.
- `busy`: high from cycle k+1 through FIN inclusive; low in the cycle after FIN.
- Back-to-back throughput: one operation per N+2 cycles.
- `Result` is written on the edge entering FIN. It is stable from FIN until the edge entering the next FIN.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Test plan
- **Multiply results (N=32).** Each has `done` in cycle k+33, `busy` high for cycles k+1…k+33, and `done` high for exactly 1 cycle.
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed and unsigned division.**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
  - Each completes at k+33.
- **Divide corner cases.** Each asserts `done` at k+1.
  - DIVU 0x1234 / 0 → 0xFFFFFFFF.
  - REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- **Handshake.**
  - `start` pulsed at k+5 and at the FIN cycle with different operands: both ignored, and the first result is unchanged.
  - `start` in the cycle after FIN: accepted.
- **`kill`.**
  - `kill` at k+10 of a DIVU: `busy` drops at k+11, `done` never rises, and `Result` retains its previous value.
  - `kill` and `start` asserted together in IDLE: no launch.
- **Reset.**
  - `reset` at k+20 of a MUL: the next cycle shows `busy`=0, `done`=0, `Result`=0.
  - A new MUL 3×5 launched afterwards returns 15 at launch+33.
